// File: rtl/turn_seq_pkg.sv
// Shared types and default constants for the turn sequencer.
package turn_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PLAYER,
      ST_DELAY,
      ST_ENEMY,
      ST_CHECK,
      ST_WIN,
      ST_LOSS
   } turn_state_t;

   typedef enum logic {
      TGT_ENEMY,
      TGT_CHECK
   } turn_target_t;

   localparam int unsigned DEFAULT_DELAY_CYCLES   = 25_000_000;
   localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 250_000_000;

endpackage

// File: rtl/delay_timer.sv
// Reloadable down-counter: start at edge n gives busy for cycles n+1..n+CYCLES,
// with done flagging the last busy cycle.
module delay_timer
   import turn_seq_pkg::*;
#(
   parameter int unsigned CYCLES = DEFAULT_DELAY_CYCLES
) (
   input  logic Clk,
   input  logic Reset_n,
   input  logic start,
   output logic busy,
   output logic done
);

   localparam int unsigned CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

   logic [CW-1:0] r_cnt;
   logic          r_busy;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_cnt  <= '0;
         r_busy <= 1'b0;
      end else if (start) begin
         r_cnt  <= CW'(CYCLES - 1);
         r_busy <= 1'b1;
      end else if (r_busy) begin
         if (r_cnt == '0) r_busy <= 1'b0;
         else             r_cnt  <= r_cnt - 1'b1;
      end
   end

   assign busy = r_busy;
   assign done = r_busy && (r_cnt == '0);

endmodule

// File: rtl/turn_sequencer.sv
// Turn-order controller: one player move, then NUM_ENEMIES enemy moves, each
// followed by a fixed delay, then a win/loss check. Optional TURN_TIMEOUT_EN adds a player forfeit timer.
module turn_sequencer
   import turn_seq_pkg::*;
#(
   parameter int unsigned NUM_ENEMIES    = 2,
   parameter int unsigned DELAY_CYCLES   = DEFAULT_DELAY_CYCLES,
   parameter int unsigned TURN_W         = 8,
   parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
   localparam int unsigned EW            = (NUM_ENEMIES > 1) ? $clog2(NUM_ENEMIES) : 1
) (
   input  logic                   Clk,
   input  logic                   Reset_n,
   input  logic                   Run,
   input  logic                   player_done,
   input  logic [NUM_ENEMIES-1:0] enemy_done,
   input  logic                   win,
   input  logic                   loss,
   output logic                   player_turn,
   output logic [NUM_ENEMIES-1:0] enemy_turn,
   output logic [EW-1:0]          enemy_idx,
   output logic                   counting,
   output logic                   game_over,
   output logic                   winner,
   output logic [TURN_W-1:0]      turn_count,
   output logic                   timed_out
);

   turn_state_t            r_state, w_next;
   turn_target_t           r_target, w_target_next;
   logic [EW-1:0]          r_idx, w_idx_next;
   logic [TURN_W-1:0]      r_turns, w_turns_next;
   logic                   r_player_turn, r_game_over, r_winner, r_timed_out;
   logic [NUM_ENEMIES-1:0] r_enemy_turn;
   logic                   w_forfeit;
   logic                   w_dly_start, w_dly_busy, w_dly_done;
   logic                   w_to_busy, w_to_done;

   assign w_dly_start = (w_next == ST_DELAY) && (r_state != ST_DELAY);

   delay_timer #(.CYCLES(DELAY_CYCLES)) u_delay (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .start   (w_dly_start),
      .busy    (w_dly_busy),
      .done    (w_dly_done)
   );

`ifdef TURN_TIMEOUT_EN
   logic w_to_start;
   assign w_to_start = (w_next == ST_PLAYER) && (r_state != ST_PLAYER);

   delay_timer #(.CYCLES(TIMEOUT_CYCLES)) u_timeout (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .start   (w_to_start),
      .busy    (w_to_busy),
      .done    (w_to_done)
   );
`else
   assign w_to_busy = 1'b0;
   assign w_to_done = 1'b0;
`endif

   always_comb begin
      w_next        = r_state;
      w_target_next = r_target;
      w_idx_next    = r_idx;
      w_turns_next  = r_turns;
      w_forfeit     = 1'b0;
      case (r_state)
         ST_IDLE: if (Run) begin
            w_next       = ST_PLAYER;
            w_idx_next   = '0;
            w_turns_next = '0;
         end
         ST_PLAYER: begin
            // A move in the expiry cycle wins over the forfeit.
            w_forfeit = w_to_busy && w_to_done && !player_done;
            if (player_done || w_forfeit) begin
               w_next        = ST_DELAY;
               w_target_next = TGT_ENEMY;
               w_idx_next    = '0;
            end
         end
         ST_DELAY: if (w_dly_done) begin
            if (r_target == TGT_CHECK) w_next = ST_CHECK;
            else                       w_next = ST_ENEMY;
         end
         ST_ENEMY: if (enemy_done[r_idx]) begin
            w_next = ST_DELAY;
            if (r_idx == EW'(NUM_ENEMIES - 1)) begin
               w_target_next = TGT_CHECK;
            end else begin
               w_target_next = TGT_ENEMY;
               w_idx_next    = r_idx + 1'b1;
            end
         end
         ST_CHECK: begin
            if (loss)     w_next = ST_LOSS;
            else if (win) w_next = ST_WIN;
            else begin
               w_next     = ST_PLAYER;
               w_idx_next = '0;
               if (r_turns != '1) w_turns_next = r_turns + 1'b1;
            end
         end
         ST_WIN, ST_LOSS: if (Run) begin
            w_next       = ST_IDLE;
            w_idx_next   = '0;
            w_turns_next = '0;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   // Strobes are registered from the next-state decode so they align with the state they describe.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_state       <= ST_IDLE;
         r_target      <= TGT_ENEMY;
         r_idx         <= '0;
         r_turns       <= '0;
         r_player_turn <= 1'b0;
         r_enemy_turn  <= '0;
         r_game_over   <= 1'b0;
         r_winner      <= 1'b0;
         r_timed_out   <= 1'b0;
      end else begin
         r_state       <= w_next;
         r_target      <= w_target_next;
         r_idx         <= w_idx_next;
         r_turns       <= w_turns_next;
         r_player_turn <= (w_next == ST_PLAYER);
         r_enemy_turn  <= (w_next == ST_ENEMY) ? (NUM_ENEMIES'(1) << w_idx_next) : '0;
         r_game_over   <= (w_next == ST_WIN) || (w_next == ST_LOSS);
         r_winner      <= (w_next == ST_WIN);
         r_timed_out   <= w_forfeit;
      end
   end

   assign player_turn = r_player_turn;
   assign enemy_turn  = r_enemy_turn;
   assign enemy_idx   = r_idx;
   assign counting    = w_dly_busy;
   assign game_over   = r_game_over;
   assign winner      = r_winner;
   assign turn_count  = r_turns;
   assign timed_out   = r_timed_out;

endmodule

// File: tb/tb_turn_sequencer.sv
// Self-checking bench for turn_sequencer; timeout scenarios run when TURN_TIMEOUT_EN is defined.
module tb_turn_sequencer;

   localparam int NE = 2;
   localparam int DC = 4;
   localparam int TW = 2;
   localparam int TO = 10;
   localparam int TMAX = (1 << TW) - 1;

   logic          Clk = 1'b0;
   logic          Reset_n = 1'b0;
   logic          Run = 1'b0;
   logic          player_done = 1'b0;
   logic [NE-1:0] enemy_done = '0;
   logic          win = 1'b0;
   logic          loss = 1'b0;
   logic          player_turn;
   logic [NE-1:0] enemy_turn;
   logic [0:0]    enemy_idx;
   logic          counting;
   logic          game_over;
   logic          winner;
   logic [TW-1:0] turn_count;
   logic          timed_out;
   logic [NE+TW+5:0] all_out;

   int n_tests = 0;
   int n_fail  = 0;

   assign all_out = {player_turn, enemy_turn, enemy_idx, counting, game_over,
                     winner, turn_count, timed_out};

   turn_sequencer #(
      .NUM_ENEMIES    (NE),
      .DELAY_CYCLES   (DC),
      .TURN_W         (TW),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .Clk         (Clk),
      .Reset_n     (Reset_n),
      .Run         (Run),
      .player_done (player_done),
      .enemy_done  (enemy_done),
      .win         (win),
      .loss        (loss),
      .player_turn (player_turn),
      .enemy_turn  (enemy_turn),
      .enemy_idx   (enemy_idx),
      .counting    (counting),
      .game_over   (game_over),
      .winner      (winner),
      .turn_count  (turn_count),
      .timed_out   (timed_out)
   );

   always #5 Clk = ~Clk;

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic clear_inputs();
      Run = 1'b0; player_done = 1'b0; win = 1'b0; loss = 1'b0; enemy_done = '0;
   endtask

   task automatic do_reset();
      clear_inputs();
      Reset_n = 1'b0;
      step();
      step();
      Reset_n = 1'b1;
   endtask

   task automatic start_game();
      Run = 1'b1;
      step();
      Run = 1'b0;
   endtask

   // Drives a full round with every done in the first cycle of its turn; ends in the CHECK cycle.
   task automatic drive_to_check();
      player_done = 1'b1;
      step();
      player_done = 1'b0;
      repeat (DC) step();
      for (int k = 0; k < NE; k++) begin
         enemy_done = '0;
         enemy_done[k] = 1'b1;
         step();
         enemy_done = '0;
         repeat (DC) step();
      end
   endtask

   task automatic test_reset();
      clear_inputs();
      Reset_n = 1'b0;
      #3;
      n_tests++;
      if (all_out !== '0) begin
         n_fail++; $display("FAIL reset_outputs: got %b want 0", all_out);
      end
      step();
      Reset_n = 1'b1;
      step();
      n_tests++;
      if (all_out !== '0) begin
         n_fail++; $display("FAIL idle_outputs: got %b want 0", all_out);
      end
   endtask

   task automatic test_basic_round();
      do_reset();
      start_game();
      n_tests++;
      if ({player_turn, counting, enemy_turn, turn_count, enemy_idx} !== {1'b1, 1'b0, 2'b00, 2'b00, 1'b0}) begin
         n_fail++; $display("FAIL basic_player_entry: pt=%b cnt=%b et=%b tc=%0d idx=%0d want pt=1 cnt=0 et=00 tc=0 idx=0",
                            player_turn, counting, enemy_turn, turn_count, enemy_idx);
      end
      step();
      player_done = 1'b1;
      step();
      player_done = 1'b0;
      for (int i = 0; i < DC; i++) begin
         n_tests++;
         if ({counting, player_turn, enemy_turn} !== 4'b1000) begin
            n_fail++; $display("FAIL basic_player_delay[%0d]: cnt/pt/et=%b want 1000", i, {counting, player_turn, enemy_turn});
         end
         player_done = (i == 1);
         step();
         player_done = 1'b0;
      end
      n_tests++;
      if ({enemy_turn, enemy_idx, counting} !== {2'b01, 1'b0, 1'b0}) begin
         n_fail++; $display("FAIL basic_enemy0: et=%b idx=%0d cnt=%b want et=01 idx=0 cnt=0", enemy_turn, enemy_idx, counting);
      end
      enemy_done = 2'b10;
      for (int i = 0; i < 3; i++) begin
         step();
         n_tests++;
         if ({enemy_turn, counting} !== 3'b010) begin
            n_fail++; $display("FAIL filter_wrong_enemy[%0d]: et=%b cnt=%b want et=01 cnt=0", i, enemy_turn, counting);
         end
      end
      enemy_done = 2'b01;
      step();
      enemy_done = '0;
      for (int i = 0; i < DC; i++) begin
         n_tests++;
         if ({counting, enemy_idx, enemy_turn} !== 4'b1100) begin
            n_fail++; $display("FAIL basic_enemy_delay[%0d]: cnt/idx/et=%b want 1100", i, {counting, enemy_idx, enemy_turn});
         end
         step();
      end
      n_tests++;
      if ({enemy_turn, player_turn} !== 3'b100) begin
         n_fail++; $display("FAIL basic_enemy1: et=%b pt=%b want et=10 pt=0", enemy_turn, player_turn);
      end
      enemy_done = 2'b10;
      step();
      enemy_done = '0;
      repeat (DC) step();
      n_tests++;
      if ({player_turn, enemy_turn, counting, game_over} !== 5'b0) begin
         n_fail++; $display("FAIL basic_check_cycle: pt/et/cnt/go=%b want 00000", {player_turn, enemy_turn, counting, game_over});
      end
      step();
      n_tests++;
      if ({player_turn, turn_count, enemy_idx} !== {1'b1, 2'd1, 1'b0}) begin
         n_fail++; $display("FAIL basic_round_done: pt=%b tc=%0d idx=%0d want pt=1 tc=1 idx=0", player_turn, turn_count, enemy_idx);
      end
   endtask

   task automatic test_win_loss();
      do_reset();
      start_game();
      drive_to_check();
      win = 1'b1; loss = 1'b1;
      step();
      win = 1'b0; loss = 1'b0;
      for (int i = 0; i < 3; i++) begin
         n_tests++;
         if ({game_over, winner, player_turn, counting} !== 4'b1000) begin
            n_fail++; $display("FAIL loss_priority[%0d]: go/win/pt/cnt=%b want 1000", i, {game_over, winner, player_turn, counting});
         end
         win = 1'b1;
         step();
         win = 1'b0;
      end
      Run = 1'b1;
      step();
      Run = 1'b0;
      n_tests++;
      if (all_out !== '0) begin
         n_fail++; $display("FAIL loss_to_idle: got %b want 0", all_out);
      end
      start_game();
      drive_to_check();
      win = 1'b1;
      step();
      win = 1'b0;
      n_tests++;
      if ({game_over, winner} !== 2'b11) begin
         n_fail++; $display("FAIL win_only: go/win=%b want 11", {game_over, winner});
      end
      Run = 1'b1;
      step();
      Run = 1'b0;
      n_tests++;
      if (all_out !== '0) begin
         n_fail++; $display("FAIL win_to_idle: got %b want 0", all_out);
      end
   endtask

   task automatic test_mid_reset();
      do_reset();
      start_game();
      drive_to_check();
      step();
      player_done = 1'b1;
      step();
      player_done = 1'b0;
      step();
      n_tests++;
      if ({counting, turn_count} !== {1'b1, 2'd1}) begin
         n_fail++; $display("FAIL pre_reset_delay: cnt=%b tc=%0d want cnt=1 tc=1", counting, turn_count);
      end
      Reset_n = 1'b0;
      #2;
      n_tests++;
      if (all_out !== '0) begin
         n_fail++; $display("FAIL async_reset: got %b want 0", all_out);
      end
      #2;
      Reset_n = 1'b1;
      step();
      n_tests++;
      if (all_out !== '0) begin
         n_fail++; $display("FAIL post_reset_idle: got %b want 0", all_out);
      end
      start_game();
      n_tests++;
      if ({player_turn, turn_count} !== {1'b1, 2'd0}) begin
         n_fail++; $display("FAIL post_reset_start: pt=%b tc=%0d want pt=1 tc=0", player_turn, turn_count);
      end
   endtask

   task automatic test_saturation();
      do_reset();
      start_game();
      for (int r = 1; r <= 5; r++) begin
         drive_to_check();
         step();
         n_tests++;
         if (int'(turn_count) != ((r > TMAX) ? TMAX : r)) begin
            n_fail++; $display("FAIL saturation[%0d]: tc=%0d want %0d", r, turn_count, (r > TMAX) ? TMAX : r);
         end
      end
   endtask

   task automatic test_random_rounds();
      int exp_turns;
      int pw, ew, r;
      logic exp_loss, exp_win;
      logic [NE-1:0] oh;
      do_reset();
      start_game();
      exp_turns = 0;
      for (int round = 0; round < 40; round++) begin
         pw = $urandom_range(0, 5);
         for (int i = 0; i < pw; i++) begin
            enemy_done = NE'($urandom); win = 1'($urandom); loss = 1'($urandom);
            n_tests++;
            if ({player_turn, enemy_turn, counting} !== 4'b1000 || int'(turn_count) != exp_turns) begin
               n_fail++; $display("FAIL rand_player: pt/et/cnt=%b tc=%0d want 1000 tc=%0d",
                                  {player_turn, enemy_turn, counting}, turn_count, exp_turns);
            end
            step();
         end
         clear_inputs();
         player_done = 1'b1;
         step();
         for (int k = 0; k <= NE; k++) begin
            for (int d = 0; d < DC; d++) begin
               player_done = 1'($urandom); enemy_done = NE'($urandom);
               win = 1'($urandom); loss = 1'($urandom);
               n_tests++;
               if ({counting, player_turn, enemy_turn} !== 4'b1000) begin
                  n_fail++; $display("FAIL rand_delay: cnt/pt/et=%b want 1000", {counting, player_turn, enemy_turn});
               end
               step();
            end
            clear_inputs();
            if (k == NE) break;
            oh = '0;
            oh[k] = 1'b1;
            ew = $urandom_range(0, 3);
            for (int i = 0; i < ew; i++) begin
               enemy_done = NE'($urandom) & ~oh;
               player_done = 1'($urandom); win = 1'($urandom); loss = 1'($urandom);
               n_tests++;
               if (enemy_turn !== oh || enemy_idx !== k[0:0] || counting !== 1'b0) begin
                  n_fail++; $display("FAIL rand_enemy: et=%b idx=%0d cnt=%b want et=%b idx=%0d cnt=0",
                                     enemy_turn, enemy_idx, counting, oh, k);
               end
               step();
            end
            clear_inputs();
            enemy_done = NE'($urandom) | oh;
            step();
         end
         n_tests++;
         if ({player_turn, enemy_turn, counting, game_over} !== 5'b0) begin
            n_fail++; $display("FAIL rand_check: pt/et/cnt/go=%b want 00000", {player_turn, enemy_turn, counting, game_over});
         end
         r = $urandom_range(0, 9);
         exp_loss = (r == 0) || (r == 1);
         exp_win  = (r == 1) || (r == 2);
         loss = exp_loss; win = exp_win;
         step();
         clear_inputs();
         if (exp_loss || exp_win) begin
            n_tests++;
            if ({game_over, winner, player_turn} !== {1'b1, !exp_loss, 1'b0}) begin
               n_fail++; $display("FAIL rand_outcome: go/win/pt=%b want %b", {game_over, winner, player_turn}, {1'b1, !exp_loss, 1'b0});
            end
            Run = 1'b1;
            step();
            Run = 1'b0;
            n_tests++;
            if (all_out !== '0) begin
               n_fail++; $display("FAIL rand_restart_idle: got %b want 0", all_out);
            end
            start_game();
            exp_turns = 0;
         end else begin
            exp_turns = (exp_turns < TMAX) ? exp_turns + 1 : TMAX;
            n_tests++;
            if (player_turn !== 1'b1 || int'(turn_count) != exp_turns || enemy_idx !== 1'b0) begin
               n_fail++; $display("FAIL rand_next_round: pt=%b tc=%0d idx=%0d want pt=1 tc=%0d idx=0",
                                  player_turn, turn_count, enemy_idx, exp_turns);
            end
         end
      end
   endtask

`ifdef TURN_TIMEOUT_EN
   task automatic test_timeout();
      do_reset();
      start_game();
      for (int i = 0; i < TO; i++) begin
         n_tests++;
         if ({player_turn, timed_out, counting} !== 3'b100) begin
            n_fail++; $display("FAIL timeout_wait[%0d]: pt/to/cnt=%b want 100", i, {player_turn, timed_out, counting});
         end
         step();
      end
      n_tests++;
      if ({counting, timed_out, player_turn} !== 3'b110) begin
         n_fail++; $display("FAIL timeout_pulse: cnt/to/pt=%b want 110", {counting, timed_out, player_turn});
      end
      step();
      n_tests++;
      if ({counting, timed_out} !== 2'b10) begin
         n_fail++; $display("FAIL timeout_pulse_width: cnt/to=%b want 10", {counting, timed_out});
      end
      repeat (DC - 1) step();
      n_tests++;
      if (enemy_turn !== 2'b01) begin
         n_fail++; $display("FAIL timeout_to_enemy: et=%b want 01", enemy_turn);
      end
      do_reset();
      start_game();
      repeat (TO - 1) step();
      player_done = 1'b1;
      step();
      player_done = 1'b0;
      n_tests++;
      if ({counting, timed_out} !== 2'b10) begin
         n_fail++; $display("FAIL timeout_same_cycle: cnt/to=%b want 10", {counting, timed_out});
      end
   endtask
`else
   task automatic test_no_timeout();
      do_reset();
      start_game();
      for (int i = 0; i < 30; i++) begin
         n_tests++;
         if ({player_turn, timed_out, counting} !== 3'b100) begin
            n_fail++; $display("FAIL no_timeout[%0d]: pt/to/cnt=%b want 100", i, {player_turn, timed_out, counting});
         end
         step();
      end
   endtask
`endif

   initial begin
      test_reset();
      test_basic_round();
      test_win_loss();
      test_mid_reset();
      test_saturation();
      test_random_rounds();
`ifdef TURN_TIMEOUT_EN
      test_timeout();
`else
      test_no_timeout();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
      $fatal(1);
   end

endmodule
